// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding, line timing constants
// and small helpers, common to the transmitter and the frame decoder.
package ws2812_pkg;

  localparam int CLK_PER_RESET = 2000;
  localparam int BIT_THRESH    = 24;
  localparam int MIN_HIGH      = 6;
  localparam int MAX_HIGH      = 60;
  localparam int T0H           = 16;
  localparam int T1H           = 32;

  typedef enum logic [1:0] {
    WAIT_RST = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    LOW      = 2'd3
  } ws_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchronizer for the asynchronous WS2812 line, plus single-cycle
// rise/fall strobes derived from the synchronized level.
module ws2812_sync_edge (
  input  logic clk,
  input  logic res_n,
  input  logic din,
  output logic sdin,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sdin = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_frame_decoder.sv
// WS2812B receive-only decoder: measures high pulse widths on the synchronized
// line, assembles 24-bit GRB pixels and reports frame boundaries and errors.
module ws2812_frame_decoder
  import ws2812_pkg::*;
#(
  parameter int CLK_PER_RESET = ws2812_pkg::CLK_PER_RESET,
  parameter int BIT_THRESH    = ws2812_pkg::BIT_THRESH,
  parameter int MIN_HIGH      = ws2812_pkg::MIN_HIGH,
  parameter int MAX_HIGH      = ws2812_pkg::MAX_HIGH
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        bit_err,
  output logic        busy,
  output ws_state_t   state_dbg
);

  localparam int LW = $clog2(CLK_PER_RESET + 1);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam logic [LW-1:0] LOW_LIM  = LW'(CLK_PER_RESET);
  localparam logic [HW-1:0] HIGH_LIM = HW'(MAX_HIGH);
  localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] THRESH   = HW'(BIT_THRESH);

  logic sdin, rise, fall;

  ws2812_sync_edge u_sync (
    .clk  (clk),
    .res_n(res_n),
    .din  (din),
    .sdin (sdin),
    .rise (rise),
    .fall (fall)
  );

  ws_state_t   state, state_d;
  logic [LW-1:0] low_cnt, low_cnt_d, low_inc;
  logic [HW-1:0] high_cnt, high_cnt_d;
  logic [4:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  pix_cnt, pix_cnt_d;
  // Holds the 23 earlier bits; the 24th goes straight into pixel_data.
  logic [22:0] shreg, shreg_d;
  logic [23:0] pixel_data_d;
  logic [7:0]  pixel_index_d, frame_len_d;
  logic        pixel_valid_d, frame_done_d, bit_err_d, busy_d;
  logic        bit_v, abort;

  assign low_inc   = (low_cnt == LOW_LIM) ? low_cnt : low_cnt + 1'b1;
  assign state_dbg = state;

  always_comb begin
    state_d       = state;
    low_cnt_d     = low_cnt;
    high_cnt_d    = high_cnt;
    bit_cnt_d     = bit_cnt;
    pix_cnt_d     = pix_cnt;
    shreg_d       = shreg;
    pixel_data_d  = pixel_data;
    pixel_index_d = pixel_index;
    frame_len_d   = frame_len;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    bit_err_d     = 1'b0;
    busy_d        = busy;
    bit_v         = 1'b0;
    abort         = 1'b0;
    unique case (state)
      WAIT_RST: begin
        if (sdin) begin
          low_cnt_d = '0;
        end else if (low_inc == LOW_LIM) begin
          low_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          low_cnt_d = low_inc;
        end
      end
      IDLE: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = HW'(1);
          busy_d     = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          if (high_cnt < MIN_H) begin
            abort = 1'b1;
          end else begin
            bit_v   = (high_cnt >= THRESH);
            shreg_d = {shreg[21:0], bit_v};
            if (bit_cnt == 5'd23) begin
              pixel_data_d  = {shreg, bit_v};
              pixel_valid_d = 1'b1;
              pixel_index_d = pix_cnt;
              pix_cnt_d     = sat_inc8(pix_cnt);
              bit_cnt_d     = '0;
            end else begin
              bit_cnt_d = bit_cnt + 5'd1;
            end
            state_d   = LOW;
            low_cnt_d = LW'(1);
          end
        end else if (high_cnt == HIGH_LIM) begin
          abort = 1'b1;
        end else begin
          high_cnt_d = high_cnt + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = HW'(1);
        end else if (low_inc == LOW_LIM) begin
          // A trailing partial pixel is reported but its bits are dropped.
          frame_done_d = 1'b1;
          frame_len_d  = pix_cnt;
          bit_err_d    = (bit_cnt != 5'd0);
          bit_cnt_d    = '0;
          pix_cnt_d    = '0;
          busy_d       = 1'b0;
          low_cnt_d    = '0;
          state_d      = IDLE;
        end else begin
          low_cnt_d = low_inc;
        end
      end
      default: state_d = WAIT_RST;
    endcase
    if (abort) begin
      bit_err_d  = 1'b1;
      state_d    = WAIT_RST;
      low_cnt_d  = '0;
      high_cnt_d = '0;
      bit_cnt_d  = '0;
      pix_cnt_d  = '0;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= WAIT_RST;
      low_cnt     <= '0;
      high_cnt    <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shreg       <= '0;
      pixel_data  <= '0;
      pixel_index <= '0;
      frame_len   <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      low_cnt     <= low_cnt_d;
      high_cnt    <= high_cnt_d;
      bit_cnt     <= bit_cnt_d;
      pix_cnt     <= pix_cnt_d;
      shreg       <= shreg_d;
      pixel_data  <= pixel_data_d;
      pixel_index <= pixel_index_d;
      frame_len   <= frame_len_d;
      pixel_valid <= pixel_valid_d;
      frame_done  <= frame_done_d;
      bit_err     <= bit_err_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_decoder.sv
// Bench for ws2812_frame_decoder: pulse-level stimulus, a frame-level
// reference model feeding an expected-event queue, and an output monitor.
module tb_ws2812_frame_decoder;
  import ws2812_pkg::*;

  localparam int W      = 35;
  localparam int IDLE_N = CLK_PER_RESET + 40;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_len;
  logic        bit_err;
  logic        busy;
  ws_state_t   state_dbg;

  ws2812_frame_decoder dut (
    .clk        (clk),
    .res_n      (res_n),
    .din        (din),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .bit_err    (bit_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // Event word: {pixel_valid, frame_done, bit_err, index/len, data}
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  bit          armed;
  int          m_bits, m_pix;
  logic [23:0] m_word, m_last;

  function automatic logic [W-1:0] ev_pixel(input int idx, input logic [23:0] d);
    return {3'b100, 8'(idx), d};
  endfunction

  function automatic logic [W-1:0] ev_frame(input int len, input bit err, input logic [23:0] d);
    return {2'b01, err, 8'(len), d};
  endfunction

  function automatic logic [W-1:0] ev_err();
    return {3'b001, 8'h00, 24'h000000};
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  logic [W-1:0] mon_act, mon_exp;
  always @(negedge clk) begin
    if (res_n && (pixel_valid || frame_done || bit_err)) begin
      mon_act = {pixel_valid, frame_done, bit_err,
                 frame_done ? frame_len : (pixel_valid ? pixel_index : 8'h00),
                 (pixel_valid || frame_done) ? pixel_data : 24'h000000};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event act=%h exp=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL event act=%h exp=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks (called on a falling clock edge) ----------------
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    if (armed) begin
      if (hi < MIN_HIGH || hi > MAX_HIGH) begin
        exp_q.push_back(ev_err());
        armed  = 1'b0;
        m_bits = 0;
        m_pix  = 0;
      end else begin
        m_word = {m_word[22:0], (hi >= BIT_THRESH)};
        m_bits++;
        if (m_bits % 24 == 0) begin
          exp_q.push_back(ev_pixel(sat255(m_pix), m_word));
          m_last = m_word;
          m_pix++;
        end
      end
    end
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic idle_low(input int n);
    if (n >= CLK_PER_RESET + 20) begin
      if (armed && m_bits > 0)
        exp_q.push_back(ev_frame(sat255(m_pix), (m_bits % 24) != 0, m_last));
      armed  = 1'b1;
      m_bits = 0;
      m_pix  = 0;
    end
    hold(1'b0, n);
  endtask

  // mode 0: nominal T0H/T1H timing, 1: full legal random, 2: narrow random, 3: fastest
  task automatic send_bit(input bit b, input int mode);
    int hi, lo;
    case (mode)
      0: begin hi = b ? T1H : T0H; lo = b ? 18 : 34; end
      1: begin
        hi = b ? int'($urandom_range(MAX_HIGH, BIT_THRESH)) : int'($urandom_range(BIT_THRESH - 1, MIN_HIGH));
        lo = int'($urandom_range(40, 2));
      end
      2: begin
        hi = b ? BIT_THRESH + int'($urandom_range(4, 0)) : MIN_HIGH + int'($urandom_range(4, 0));
        lo = int'($urandom_range(4, 1));
      end
      default: begin hi = b ? BIT_THRESH : MIN_HIGH; lo = 1; end
    endcase
    pulse(hi, lo);
  endtask

  task automatic send_word(input logic [23:0] w, input int mode);
    for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
  endtask

  task automatic send_bits(input int n, input int mode);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)), mode);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n  = 1'b0;
    din    = 1'b0;
    armed  = 1'b0;
    m_bits = 0;
    m_pix  = 0;
    m_word = '0;
    m_last = '0;
    repeat (3) @(negedge clk);
    check("rst_pixel_data", 32'(pixel_data), 32'h0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    check("rst_pixel_index", 32'(pixel_index), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_frame_len", 32'(frame_len), 32'h0);
    check("rst_bit_err", 32'(bit_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(WAIT_RST));
    res_n = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int npix;
    do_reset();
    idle_low(IDLE_N);

    // single nominal-timing pixel
    send_word(24'hFF0000, 0);
    check("busy_in_frame", 32'(busy), 32'h1);
    idle_low(IDLE_N);
    check("busy_after_frame", 32'(busy), 32'h0);
    check("pixel_data_hold", 32'(pixel_data), 32'hFF0000);

    // twelve back-to-back pixels
    for (int i = 0; i < 12; i++) send_word(24'h00FF00, 2);
    idle_low(IDLE_N);

    // threshold and width boundaries inside one pixel
    pulse(23, 10);
    pulse(24, 10);
    pulse(MIN_HIGH, 10);
    pulse(MAX_HIGH, 10);
    send_bits(20, 2);
    idle_low(IDLE_N);

    // glitch mid-frame
    send_bits(3, 2);
    check("busy_before_glitch", 32'(busy), 32'h1);
    pulse(5, 20);
    check("busy_after_glitch", 32'(busy), 32'h0);
    check("state_after_glitch", 32'(state_dbg), 32'(WAIT_RST));
    idle_low(IDLE_N);

    // partial pixel at frame end, then index restarts
    send_bits(10, 1);
    idle_low(IDLE_N);
    send_word(24'($urandom), 1);
    idle_low(IDLE_N);

    // reset mid-frame; a pixel after a short low period must be ignored
    send_bits(12, 2);
    do_reset();
    idle_low(CLK_PER_RESET - 500);
    send_word(24'($urandom), 3);
    idle_low(IDLE_N);
    send_word(24'($urandom), 1);
    idle_low(IDLE_N);

    // stuck-high line mid-frame
    send_bits(5, 2);
    pulse(70, 20);
    check("busy_after_stuck", 32'(busy), 32'h0);
    check("state_after_stuck", 32'(state_dbg), 32'(WAIT_RST));
    idle_low(IDLE_N);
    pulse(MAX_HIGH + 1, 20);
    idle_low(IDLE_N);

    // random frame with random trailing partial bits
    npix = int'($urandom_range(3, 1));
    for (int i = 0; i < npix; i++) send_word(24'($urandom), 2);
    send_bits(int'($urandom_range(23, 0)), 2);
    idle_low(IDLE_N);

    // pixel counter saturation
    for (int i = 0; i < 257; i++) send_word(24'h000000, 3);
    idle_low(IDLE_N);

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
